// File: rtl/matrixmult_seq_if.sv
// Handshake and status bundle between the FSL host side and matrixmult_seq.
// master = host/bench side, slave = sequencer side.
interface matrixmult_seq_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic [DATA_W-1:0] FSL_S_Data;
    logic              FSL_S_Control;
    logic              FSL_S_Exists;
    logic              FSL_S_Read;
    logic [DATA_W-1:0] core_data;
    logic              core_exists;
    logic              core_read;
    logic              core_res_valid;
    logic              matrix_loaded;
    logic              busy;
    logic [CNT_W-1:0]  pixel_count;
    logic              err_nomtx;
    logic              err_spur;

    modport master (
        output FSL_S_Data, FSL_S_Control, FSL_S_Exists, core_read, core_res_valid,
        input  FSL_S_Read, core_data, core_exists, matrix_loaded, busy, pixel_count,
               err_nomtx, err_spur
    );

    modport slave (
        input  FSL_S_Data, FSL_S_Control, FSL_S_Exists, core_read, core_res_valid,
        output FSL_S_Read, core_data, core_exists, matrix_loaded, busy, pixel_count,
               err_nomtx, err_spur
    );
endinterface

// File: rtl/matrixmult_seq.sv
// Sequencer for the matrixmult coprocessor: holds a DIMxDIM matrix, replays each pixel as an
// interleaved row/pixel stream. Define MATRIXMULT_SEQ_PREFETCH_EN to buffer the next pixel during WAIT_RES.
module matrixmult_seq #(
    parameter int DATA_W = 32,
    parameter int DIM    = 4,
    parameter int CNT_W  = 16
) (
    input  logic            FSL_Clk,
    input  logic            FSL_Rst,
    matrixmult_seq_if.slave bus
);
    localparam int MTX_N = DIM * DIM;
    localparam int STR_N = 2 * MTX_N;
    localparam int IDX_W = $clog2(MTX_N);
    localparam int PIX_W = $clog2(DIM);
    localparam int K_W   = $clog2(STR_N);
    localparam int RES_W = $clog2(DIM) + 1;

    typedef enum logic [2:0] {IDLE, LOAD_MTX, LOAD_PIX, ISSUE, WAIT_RES} state_t;

    state_t            state;
    logic [DATA_W-1:0] m   [MTX_N];
    logic [DATA_W-1:0] pix [DIM];
    logic [IDX_W-1:0]  idx;
    logic [K_W-1:0]    k;
    logic [RES_W-1:0]  res_cnt;
    logic [RES_W-1:0]  res_nxt;
    logic              res_done;
    logic              s_read;
    logic [DATA_W-1:0] core_data_r;
    logic              core_exists_r;
    logic              matrix_loaded_r;
    logic [CNT_W-1:0]  pixel_count_r;
    logic              err_nomtx_r;
    logic              err_spur_r;
`ifdef MATRIXMULT_SEQ_PREFETCH_EN
    logic [IDX_W-1:0]  pf_cnt;
`endif

    // Even stream slots carry matrix element k/2 (row-major), odd slots the matching pixel element.
    function automatic logic [DATA_W-1:0] stream_word(input logic [K_W-1:0] kk);
        logic [K_W-2:0] half;
        half = kk[K_W-1:1];
        if (!kk[0])
            return m[half];
        return pix[half[PIX_W-1:0]];
    endfunction

    always_comb begin
        s_read = 1'b0;
        case (state)
            IDLE, LOAD_MTX, LOAD_PIX: s_read = bus.FSL_S_Exists;
`ifdef MATRIXMULT_SEQ_PREFETCH_EN
            WAIT_RES: s_read = bus.FSL_S_Exists && !bus.FSL_S_Control && (idx < IDX_W'(DIM));
`endif
            default:                  s_read = 1'b0;
        endcase
        if (!FSL_Rst)
            s_read = 1'b0;
    end

    // Results may already arrive during ISSUE; the running count carries into WAIT_RES.
    assign res_nxt  = res_cnt + RES_W'(bus.core_res_valid);
    assign res_done = (res_nxt >= RES_W'(DIM));
`ifdef MATRIXMULT_SEQ_PREFETCH_EN
    assign pf_cnt   = idx + IDX_W'(s_read);
`endif

    always_ff @(posedge FSL_Clk) begin
        if (!FSL_Rst) begin
            state           <= IDLE;
            idx             <= '0;
            k               <= '0;
            res_cnt         <= '0;
            core_data_r     <= '0;
            core_exists_r   <= 1'b0;
            matrix_loaded_r <= 1'b0;
            pixel_count_r   <= '0;
            err_nomtx_r     <= 1'b0;
            err_spur_r      <= 1'b0;
        end else begin
            if (bus.core_res_valid && (state inside {IDLE, LOAD_MTX, LOAD_PIX}))
                err_spur_r <= 1'b1;
            case (state)
                IDLE: if (s_read) begin
                    if (bus.FSL_S_Control) begin
                        m[0]            <= bus.FSL_S_Data;
                        idx             <= IDX_W'(1);
                        matrix_loaded_r <= 1'b0;
                        state           <= LOAD_MTX;
                    end else if (matrix_loaded_r) begin
                        pix[0] <= bus.FSL_S_Data;
                        idx    <= IDX_W'(1);
                        state  <= LOAD_PIX;
                    end else begin
                        err_nomtx_r <= 1'b1;
                    end
                end
                LOAD_MTX: if (s_read) begin
                    if (bus.FSL_S_Control) begin
                        m[0] <= bus.FSL_S_Data;
                        idx  <= IDX_W'(1);
                    end else begin
                        m[idx] <= bus.FSL_S_Data;
                        if (idx == IDX_W'(MTX_N - 1)) begin
                            matrix_loaded_r <= 1'b1;
                            state           <= IDLE;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                LOAD_PIX: if (s_read) begin
                    if (bus.FSL_S_Control) begin
                        m[0]            <= bus.FSL_S_Data;
                        idx             <= IDX_W'(1);
                        matrix_loaded_r <= 1'b0;
                        state           <= LOAD_MTX;
                    end else begin
                        pix[idx[PIX_W-1:0]] <= bus.FSL_S_Data;
                        if (idx == IDX_W'(DIM - 1)) begin
                            k             <= '0;
                            res_cnt       <= '0;
                            core_exists_r <= 1'b1;
                            core_data_r   <= m[0];
                            state         <= ISSUE;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                ISSUE: begin
                    res_cnt <= res_done ? RES_W'(DIM) : res_nxt;
                    if (bus.core_read) begin
                        if (k == K_W'(STR_N - 1)) begin
                            core_exists_r <= 1'b0;
                            idx           <= '0;
                            state         <= WAIT_RES;
                        end else begin
                            k           <= k + K_W'(1);
                            core_data_r <= stream_word(k + K_W'(1));
                        end
                    end
                end
                WAIT_RES: begin
`ifdef MATRIXMULT_SEQ_PREFETCH_EN
                    if (s_read) begin
                        pix[idx[PIX_W-1:0]] <= bus.FSL_S_Data;
                        idx                 <= pf_cnt;
                    end
`endif
                    if (res_done) begin
                        res_cnt       <= '0;
                        pixel_count_r <= pixel_count_r + CNT_W'(1);
`ifdef MATRIXMULT_SEQ_PREFETCH_EN
                        if (pf_cnt == IDX_W'(DIM)) begin
                            k             <= '0;
                            core_exists_r <= 1'b1;
                            core_data_r   <= m[0];
                            state         <= ISSUE;
                        end else if (pf_cnt != '0) begin
                            state <= LOAD_PIX;
                        end else begin
                            state <= IDLE;
                        end
`else
                        state <= IDLE;
`endif
                    end else begin
                        res_cnt <= res_nxt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.FSL_S_Read    = s_read;
    assign bus.core_data     = core_data_r;
    assign bus.core_exists   = core_exists_r;
    assign bus.matrix_loaded = matrix_loaded_r;
    assign bus.busy          = (state != IDLE);
    assign bus.pixel_count   = pixel_count_r;
    assign bus.err_nomtx     = err_nomtx_r;
    assign bus.err_spur      = err_spur_r;
endmodule

// File: tb/tb_matrixmult_seq.sv
// Self-checking bench for matrixmult_seq: table of pixels replayed against a stream scoreboard,
// plus hand-written reset, no-matrix, pixel-abort and mid-stream reset sequences.
module tb_matrixmult_seq;
    localparam int DATA_W = 32;
    localparam int DIM    = 4;
    localparam int CNT_W  = 16;

    typedef struct packed {
        logic [3:0][31:0] pix;
        logic [1:0]       mode;
        logic [15:0]      exp_count;
        logic [31:0]      exp_first;
    } vec_t;

    logic FSL_Clk = 1'b0;
    logic FSL_Rst = 1'b0;

    matrixmult_seq_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    matrixmult_seq #(.DATA_W(DATA_W), .DIM(DIM), .CNT_W(CNT_W)) dut (
        .FSL_Clk (FSL_Clk),
        .FSL_Rst (FSL_Rst),
        .bus     (bus)
    );

    always #5 FSL_Clk = ~FSL_Clk;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] sb [$];
    logic [31:0] mtx [16];
    int          read_mode = 0;
    logic        held_valid = 1'b0;
    logic [31:0] held_data;
    vec_t        vecs [3];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] a, b, c, d, input logic [1:0] mode,
                                input logic [15:0] cnt, input logic [31:0] first);
        vec_t v;
        v.pix[0] = a; v.pix[1] = b; v.pix[2] = c; v.pix[3] = d;
        v.mode = mode; v.exp_count = cnt; v.exp_first = first;
        return v;
    endfunction

    // Core-side scoreboard: every accepted word must be the next expected stream word.
    always @(negedge FSL_Clk) begin
        if (FSL_Rst && bus.core_exists) begin
            if (held_valid)
                check("core_data hold", 64'(bus.core_data), 64'(held_data));
            if (bus.core_read) begin
                held_valid = 1'b0;
                if (sb.size() == 0)
                    check("unexpected core word", 64'(bus.core_exists), 64'd0);
                else
                    check("stream word", 64'(bus.core_data), 64'(sb.pop_front()));
            end else begin
                held_valid = 1'b1;
                held_data  = bus.core_data;
            end
        end else begin
            held_valid = 1'b0;
        end
    end

    initial begin
        bus.core_read = 1'b0;
        forever begin
            @(posedge FSL_Clk); #1;
            case (read_mode)
                0:       bus.core_read = 1'b1;
                1:       bus.core_read = ~bus.core_read;
                default: bus.core_read = 1'b0;
            endcase
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_word(input logic [31:0] d, input logic c);
        int n = 0;
        bus.FSL_S_Data    = d;
        bus.FSL_S_Control = c;
        bus.FSL_S_Exists  = 1'b1;
        forever begin
            @(negedge FSL_Clk);
            if (bus.FSL_S_Read) break;
            n++;
            if (n > 100) begin
                check("upstream accept timeout", 64'(bus.FSL_S_Read), 64'd1);
                break;
            end
        end
        @(posedge FSL_Clk); #1;
        bus.FSL_S_Exists = 1'b0;
    endtask

    task automatic load_matrix(input logic [31:0] first, input logic [31:0] step);
        mtx[0] = first;
        for (int i = 1; i < 16; i++) mtx[i] = 32'h3E000000 + step * 32'(i);
        for (int i = 0; i < 16; i++) send_word(mtx[i], i == 0);
    endtask

    task automatic push_stream(input logic [3:0][31:0] p);
        for (int i = 0; i < 32; i++)
            sb.push_back((i % 2 == 0) ? mtx[i / 2] : p[(i / 2) % 4]);
    endtask

    task automatic res_pulses(input int n);
        repeat (n) begin
            bus.core_res_valid = 1'b1;
            @(posedge FSL_Clk); #1;
            bus.core_res_valid = 1'b0;
            @(posedge FSL_Clk); #1;
        end
    endtask

    task automatic wait_stream();
        int n = 0;
        while ((sb.size() != 0 || bus.core_exists) && n < 500) begin
            @(posedge FSL_Clk); #1;
            n++;
        end
        check("stream drained", 64'(sb.size()), 64'd0);
        check("core_exists after stream", 64'(bus.core_exists), 64'd0);
    endtask

    task automatic run_pixel(input vec_t v);
        read_mode = v.mode;
        push_stream(v.pix);
        for (int i = 0; i < 4; i++) send_word(v.pix[i], 1'b0);
        check("first word valid", 64'(bus.core_exists), 64'd1);
        check("first word data", 64'(bus.core_data), 64'(v.exp_first));
        wait_stream();
        res_pulses(3);
        check("busy before last result", 64'(bus.busy), 64'd1);
        res_pulses(1);
        check("pixel_count", 64'(bus.pixel_count), 64'(v.exp_count));
        check("busy after results", 64'(bus.busy), 64'd0);
    endtask

    initial begin
        vecs[0] = mk(32'hBF07AE14, 32'h4141999A, 32'hC1691EB8, 32'h4040A3D7, 2'd0, 16'd1, 32'h4124CCCD);
        vecs[1] = mk(32'h00000001, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 2'd1, 16'd2, 32'h4124CCCD);
        vecs[2] = mk(32'hDEADBEEF, 32'h12345678, 32'hA5A5A5A5, 32'h0F0F0F0F, 2'd1, 16'd3, 32'h4124CCCD);

        bus.FSL_S_Data     = '0;
        bus.FSL_S_Control  = 1'b0;
        bus.FSL_S_Exists   = 1'b1;
        bus.core_res_valid = 1'b0;

        // Reset held with upstream data pending
        repeat (2) @(posedge FSL_Clk);
        @(negedge FSL_Clk);
        check("reset S_Read", 64'(bus.FSL_S_Read), 64'd0);
        check("reset core_exists", 64'(bus.core_exists), 64'd0);
        check("reset matrix_loaded", 64'(bus.matrix_loaded), 64'd0);
        check("reset pixel_count", 64'(bus.pixel_count), 64'd0);
        check("reset err_nomtx", 64'(bus.err_nomtx), 64'd0);
        check("reset err_spur", 64'(bus.err_spur), 64'd0);
        check("reset busy", 64'(bus.busy), 64'd0);
        bus.FSL_S_Exists = 1'b0;
        @(posedge FSL_Clk); #1;
        FSL_Rst = 1'b1;
        @(posedge FSL_Clk); #1;

        // Pixel with no matrix is dropped
        send_word(32'h3F800000, 1'b0);
        check("err_nomtx set", 64'(bus.err_nomtx), 64'd1);
        repeat (3) @(posedge FSL_Clk); #1;
        check("no-matrix core_exists", 64'(bus.core_exists), 64'd0);
        check("no-matrix busy", 64'(bus.busy), 64'd0);

        load_matrix(32'h4124CCCD, 32'h00111111);
        check("matrix_loaded after 16", 64'(bus.matrix_loaded), 64'd1);

        for (int i = 0; i < 3; i++) run_pixel(vecs[i]);

        // Control on the 3rd pixel word aborts the pixel and restarts a matrix load
        read_mode = 0;
        send_word(32'h11111111, 1'b0);
        send_word(32'h22222222, 1'b0);
        check("abort busy in pixel load", 64'(bus.busy), 64'd1);
        send_word(32'h40490FDB, 1'b1);
        check("abort matrix_loaded", 64'(bus.matrix_loaded), 64'd0);
        mtx[0] = 32'h40490FDB;
        for (int i = 1; i < 16; i++) mtx[i] = 32'h3D000000 + 32'h00010203 * 32'(i);
        for (int i = 1; i < 15; i++) send_word(mtx[i], 1'b0);
        check("reload 15 words not loaded", 64'(bus.matrix_loaded), 64'd0);
        send_word(mtx[15], 1'b0);
        check("reload 16 words loaded", 64'(bus.matrix_loaded), 64'd1);
        check("abort pixel_count", 64'(bus.pixel_count), 64'd3);
        run_pixel(mk(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 2'd0, 16'd4, 32'h40490FDB));

        // Result pulse while idle
        check("err_spur clear", 64'(bus.err_spur), 64'd0);
        res_pulses(1);
        check("err_spur set", 64'(bus.err_spur), 64'd1);
        check("spur pixel_count", 64'(bus.pixel_count), 64'd4);

`ifdef MATRIXMULT_SEQ_PREFETCH_EN
        begin
            logic [3:0][31:0] pa, pb;
            pa = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
            pb = {32'h88888888, 32'h77777777, 32'h66666666, 32'h55555555};
            read_mode = 0;
            push_stream(pa);
            for (int i = 0; i < 4; i++) send_word(pa[i], 1'b0);
            wait_stream();
            for (int i = 0; i < 4; i++) send_word(pb[i], 1'b0);
            check("prefetch no early issue", 64'(bus.core_exists), 64'd0);
            res_pulses(3);
            push_stream(pb);
            bus.core_res_valid = 1'b1;
            @(posedge FSL_Clk); #1;
            bus.core_res_valid = 1'b0;
            check("prefetch issue after result", 64'(bus.core_exists), 64'd1);
            check("prefetch first word", 64'(bus.core_data), 64'(mtx[0]));
            check("prefetch pixel_count", 64'(bus.pixel_count), 64'd5);
            wait_stream();
            res_pulses(4);
            check("prefetch second count", 64'(bus.pixel_count), 64'd6);
        end
`endif

        // Reset in the middle of the stream at k=10
        begin
            int n = 0;
            logic [3:0][31:0] pr;
            pr = {32'hCAFEF00D, 32'h0BADC0DE, 32'hFEEDFACE, 32'hB16B00B5};
            read_mode = 0;
            push_stream(pr);
            for (int i = 0; i < 4; i++) send_word(pr[i], 1'b0);
            while (sb.size() > 22 && n < 200) begin
                @(posedge FSL_Clk); #1;
                n++;
            end
            check("words before reset", 64'(sb.size()), 64'd22);
            FSL_Rst          = 1'b0;
            bus.FSL_S_Exists = 1'b1;
            @(negedge FSL_Clk);
            check("reset S_Read forced", 64'(bus.FSL_S_Read), 64'd0);
            @(posedge FSL_Clk); #1;
            check("mid reset core_exists", 64'(bus.core_exists), 64'd0);
            check("mid reset busy", 64'(bus.busy), 64'd0);
            check("mid reset matrix_loaded", 64'(bus.matrix_loaded), 64'd0);
            check("mid reset pixel_count", 64'(bus.pixel_count), 64'd0);
            sb.delete();
            bus.FSL_S_Exists = 1'b0;
            @(posedge FSL_Clk); #1;
            FSL_Rst = 1'b1;
            @(posedge FSL_Clk); #1;
        end

        load_matrix(32'h4124CCCD, 32'h00111111);
        run_pixel(vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
